// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write-side frame scheduler and its burst credit check.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        CHECK      = 3'd2,
        REQ        = 3'd3,
        XFER       = 3'd4,
        DONE       = 3'd5
    } state_t;

    localparam int DEF_FRAME_PIXELS = 384000;
    localparam int DEF_BURST_LEN    = 64;

    // Bits needed to index 'value' distinct values (ceil(log2(value))).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_burst_credit.sv
// Combinational burst sizing and FIFO space check, shared with the read-side prefetcher.
module lcd_burst_credit #(
    parameter int CNT_W     = 10,
    parameter int PIX_W     = 19,
    parameter int BURST_LEN = 64,
    parameter int CEILING   = 1000
) (
    input  logic [PIX_W-1:0] pix_rem,
    input  logic [CNT_W-1:0] fifo_wr_cnt,
    output logic [7:0]       len_next,
    output logic             space_ok
);

    logic [CNT_W:0] sum;

    always_comb begin
        len_next = (32'(pix_rem) >= 32'(BURST_LEN)) ? 8'(BURST_LEN) : 8'(pix_rem);
        // One extra bit so occupancy plus burst never wraps before the compare.
        sum      = {1'b0, fifo_wr_cnt} + (CNT_W+1)'(len_next);
        space_ok = (sum <= (CNT_W+1)'(CEILING));
    end

endmodule

// File: rtl/lcd_frame_sched.sv
// Frame-level refill scheduler: splits each frame into FIFO-safe bursts and flags timing faults.
module lcd_frame_sched
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH            = 1024,
    parameter int FIFO_ALMOSTFULL_DEPTH = 1000,
    parameter int BURST_LEN             = DEF_BURST_LEN,
    parameter int FRAME_PIXELS          = DEF_FRAME_PIXELS,
    parameter int CNT_W                 = 10
) (
    input  logic             fifo_wr_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             frame_start,
    input  logic [CNT_W-1:0] fifo_wr_cnt,
    input  logic             fifo_full,
    output logic             burst_req,
    output logic [7:0]       burst_len,
    input  logic             burst_ack,
    input  logic             beat_valid,
    output logic             axis_data_sync,
    output logic             frame_done,
    output logic             frame_overrun,
    output logic             wr_overflow,
    output state_t           state
);

    localparam int PIX_W   = clog2(FRAME_PIXELS + 1);
    localparam int CEILING = (FIFO_ALMOSTFULL_DEPTH < FIFO_DEPTH) ? FIFO_ALMOSTFULL_DEPTH : FIFO_DEPTH;

    logic [PIX_W-1:0] pix_rem;
    logic [7:0]       beat_rem;
    logic             pend_start;
    logic             first;
    logic [7:0]       len_next;
    logic             space_ok;
    logic             fs_busy;
    logic             frame_last_beat;

    lcd_burst_credit #(
        .CNT_W    (CNT_W),
        .PIX_W    (PIX_W),
        .BURST_LEN(BURST_LEN),
        .CEILING  (CEILING)
    ) u_credit (
        .pix_rem    (pix_rem),
        .fifo_wr_cnt(fifo_wr_cnt),
        .len_next   (len_next),
        .space_ok   (space_ok)
    );

    // A frame_start landing on the final beat of a frame is on time, not an overrun.
    always_comb begin
        fs_busy         = frame_start && (state != IDLE) && (state != WAIT_FRAME);
        frame_last_beat = (state == XFER) && beat_valid && (beat_rem == 8'd1)
                          && (pix_rem == PIX_W'(1));
    end

    // Handshake: burst_req and burst_len stay stable from the cycle burst_req rises
    // until the cycle burst_ack is sampled high; that cycle transfers the request.
    always_ff @(posedge fifo_wr_clk) begin
        if (rst) begin
            state          <= IDLE;
            burst_req      <= 1'b0;
            burst_len      <= 8'd0;
            axis_data_sync <= 1'b0;
            frame_done     <= 1'b0;
            frame_overrun  <= 1'b0;
            wr_overflow    <= 1'b0;
            pix_rem        <= '0;
            beat_rem       <= 8'd0;
            pend_start     <= 1'b0;
            first          <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (fs_busy) begin
                pend_start <= 1'b1;
                if (!frame_last_beat) frame_overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (enable) state <= WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (frame_start || pend_start) begin
                        pix_rem    <= PIX_W'(FRAME_PIXELS);
                        first      <= 1'b1;
                        pend_start <= 1'b0;
                        state      <= CHECK;
                    end else if (!enable) begin
                        state <= IDLE;
                    end
                end
                CHECK: begin
                    if (space_ok) begin
                        burst_len <= len_next;
                        burst_req <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (burst_ack) begin
                        beat_rem       <= burst_len;
                        burst_req      <= 1'b0;
                        axis_data_sync <= first;
                        state          <= XFER;
                    end
                end
                XFER: begin
                    if (beat_valid) begin
                        beat_rem       <= beat_rem - 8'd1;
                        pix_rem        <= pix_rem - PIX_W'(1);
                        first          <= 1'b0;
                        axis_data_sync <= 1'b0;
                        if (fifo_full) wr_overflow <= 1'b1;
                        if (beat_rem == 8'd1) begin
                            if (pix_rem == PIX_W'(1))           state <= DONE;
                            else if (pend_start || frame_start) state <= WAIT_FRAME;
                            else if (!enable)                   state <= IDLE;
                            else                                state <= CHECK;
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    state      <= WAIT_FRAME;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
